// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: PC owner and fetch FIFO toward decode; define IFETCH_PERF_CNT_EN to enable fetch_count
module instr_fetch_ctrl #(
   parameter int DATA_WIDTH     = 32,
   parameter int MEM_ADDR_WIDTH = 32,
   parameter int MEM_SIZE       = 256,
   parameter int RESET_PC       = 0,
   parameter int FIFO_DEPTH     = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   output logic [MEM_ADDR_WIDTH-1:0] pc_address,
   input  logic [DATA_WIDTH-1:0]     instruction,
   input  logic                      redirect_valid,
   input  logic [MEM_ADDR_WIDTH-1:0] redirect_pc,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_WIDTH-1:0]     out_instr,
   output logic [MEM_ADDR_WIDTH-1:0] out_pc,
   output logic                      halted,
   output logic [31:0]               fetch_count
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);
   localparam logic [MEM_ADDR_WIDTH:0] LIMIT = (MEM_ADDR_WIDTH+1)'(4 * MEM_SIZE);

   typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

   state_t                    state, state_nxt;
   logic [MEM_ADDR_WIDTH-1:0] pc, pc_nxt, tgt;
   logic [MEM_ADDR_WIDTH-1:0] fifo_pc [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0]     fifo_instr [FIFO_DEPTH];
   logic [PW-1:0]             wr_ptr, rd_ptr;
   logic [PW:0]               count;
   logic                      push, pop, flush, pc_oob, tgt_oob;

   assign tgt        = {redirect_pc[MEM_ADDR_WIDTH-1:2], 2'b00};
   assign pc_oob     = {1'b0, pc} >= LIMIT;
   assign tgt_oob    = {1'b0, tgt} >= LIMIT;
   assign pop        = out_valid && out_ready;
   assign out_valid  = count != '0;
   assign out_instr  = fifo_instr[rd_ptr];
   assign out_pc     = fifo_pc[rd_ptr];
   assign pc_address = pc;
   assign halted     = state == HALT;

   // next state, next pc and push/flush decisions; redirect always wins
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      push      = 1'b0;
      flush     = 1'b0;
      case (state)
         IDLE: begin
            if (redirect_valid) begin
               flush  = 1'b1;
               pc_nxt = tgt;
            end else if (start) state_nxt = FETCH;
         end
         FETCH: begin
            if (redirect_valid) begin
               flush     = 1'b1;
               pc_nxt    = tgt;
               state_nxt = tgt_oob ? HALT : FETCH;
            end else if (pc_oob) state_nxt = HALT;
            else if (count < DEPTH_C || pop) begin
               push   = 1'b1;
               pc_nxt = pc + MEM_ADDR_WIDTH'(4);
            end
         end
         HALT: begin
            if (redirect_valid) begin
               flush     = 1'b1;
               pc_nxt    = tgt;
               state_nxt = tgt_oob ? HALT : FETCH;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // state and program counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         pc    <= MEM_ADDR_WIDTH'(RESET_PC);
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
      end
   end

   // fetch buffer pointers and occupancy; a flush discards the head even if it is being accepted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= (push && !pop) ? count + 1'b1 : (!push && pop) ? count - 1'b1 : count;
      end
   end

   // fetch buffer storage, cleared on reset so the head reads zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_pc[i]    <= '0;
            fifo_instr[i] <= '0;
         end
      end else if (push) begin
         fifo_pc[wr_ptr]    <= pc;
         fifo_instr[wr_ptr] <= instruction;
      end
   end

`ifdef IFETCH_PERF_CNT_EN
   // count accepted instructions; heads dropped by a redirect are not counted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) fetch_count <= '0;
      else if (pop && !redirect_valid) fetch_count <= fetch_count + 32'd1;
   end
`else
   assign fetch_count = '0;
`endif
endmodule

// File: doc/instr_fetch_ctrl.md
# instr_fetch_ctrl

Sequential fetch controller for the single-cycle core. Owns the program counter, drives the combinational InstructionMemory read port, and buffers fetched words in a small FIFO toward decode with a valid/ready handshake. Handles branch/jump redirects with buffer flush and halts cleanly when the PC leaves the memory image.

## Interface
Parameters:
- DATA_WIDTH, 32, instruction word width
- MEM_ADDR_WIDTH, 32, byte-address width (matches InstructionMemory)
- MEM_SIZE, 256, number of words in InstructionMemory
- RESET_PC, 0, byte address loaded on reset
- FIFO_DEPTH, 2, fetch buffer entries (power of two, ≥2)

Ports (reset is asynchronous, active-low; one clock):
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  pulse: leave IDLE and begin fetching
- pc_address  output  MEM_ADDR_WIDTH  address to InstructionMemory
- instruction  input  DATA_WIDTH  combinational read data from InstructionMemory
- redirect_valid  input  1  branch/jump taken this cycle
- redirect_pc  input  MEM_ADDR_WIDTH  target byte address
- out_valid  output  1  out_instr/out_pc valid
- out_ready  input  1  decode accepts
- out_instr  output  DATA_WIDTH  head-of-FIFO instruction
- out_pc  output  MEM_ADDR_WIDTH  byte address of out_instr
- halted  output  1  PC out of range, fetching stopped
- fetch_count  output  32  accepted-instruction counter (see Configuration)

## Operation
- States: IDLE, FETCH, HALT.
- IDLE: pc_address holds pc; no pushes. start → FETCH. redirect_valid in IDLE loads pc, stays IDLE.
- FETCH, each rising edge, priority order:
  1. redirect_valid: flush FIFO (count←0), pc ← redirect_pc & ~3; no push, no pop counted. If the new pc ≥ 4·MEM_SIZE → HALT, else stay FETCH.
  2. Else if pc ≥ 4·MEM_SIZE: no push → HALT.
  3. Else push {pc, instruction} when count < FIFO_DEPTH, or count == FIFO_DEPTH and a pop occurs this edge; pc ← pc + 4 on push.
- Pop when out_valid && out_ready (independent of push unless redirect).
- HALT: no pushes; FIFO continues to drain; halted = 1. redirect_valid to an in-range pc → FETCH, halted cleared; start ignored.
- pc arithmetic: MEM_ADDR_WIDTH-bit, wraps modulo 2^MEM_ADDR_WIDTH; range check catches it before wrap in practice.
- out_valid = (count != 0); out_instr/out_pc are the FIFO head, stable while out_valid && !out_ready.
- pc_address = pc at all times (combinational from register).

## Timing
- Reset values: pc = RESET_PC, state IDLE, count 0, out_valid 0, out_instr 0, out_pc 0, halted 0, fetch_count 0.
- Reset mid-operation: asynchronous, immediately returns all outputs to reset values; FIFO contents discarded.
- start sampled at edge N → FETCH from N; first push at edge N+1; out_valid high after N+1.
- Sustained throughput: 1 instruction/cycle with out_ready held high.
- Full FIFO and out_ready low: pc holds, pc_address stable, no push.
- Redirect at edge R: out_valid low after R; first target instruction visible after R+1.
- Redirect coincident with out_ready: the head is dropped, not counted.

## Configuration
- IFETCH_PERF_CNT_EN defined: fetch_count increments by 1 on every pop (out_valid && out_ready, no redirect same edge); wraps at 2^32; cleared only by reset.
- Undefined: counter logic omitted; fetch_count tied to 0.

## Test plan
Bench memory model drives instruction = 32'hA000_0000 | pc_address.
- Reset, start pulse, out_ready = 1 → out_pc 0,4,8,12 on consecutive cycles; out_instr A000_0000, A000_0004, A000_0008, A000_000C.
- out_ready = 0 for 5 cycles after start → count saturates at 2; pc_address holds 8; on release, out_pc 0,4,8 in order, none lost or duplicated.
- Redirect to 32'h0000_0043 while FIFO holds 2 → next out_valid after one empty cycle; out_pc = 0x40, out_instr = A000_0040.
- Fetch runs to 0x3FC with MEM_SIZE = 256 → last out_pc 0x3FC, then halted = 1, out_valid falls after drain; redirect to 0x10 resumes at 0x10.
- rst_n asserted low mid-stream with out_valid = 1 → out_valid, halted, count 0 immediately; pc_address = RESET_PC.
- With IFETCH_PERF_CNT_EN: 10 handshakes plus a redirect-dropped head → fetch_count = 10; without the macro, fetch_count = 0 throughout.
